// File: rtl/data_sram_resp.sv
// data_sram_resp: CPU data SRAM responder; byte-enabled word array, 1-cycle write-first reads,
// address-range checking and access counters. Define DATA_SRAM_TIMER_EN to map a timer at TIMER_ADDR.
module data_sram_resp #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] TIMER_ADDR = 32'h1FAF_E000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        resp_err,
    output logic [31:0] stat_rd_cnt,
    output logic [31:0] stat_wr_cnt
);
    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned TAG_LSB = DEPTH_LOG2 + 2;

    logic [31:0]           mem_q [DEPTH];
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [31:0]           rd_cnt_q, rd_cnt_d;
    logic [31:0]           wr_cnt_q, wr_cnt_d;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  ram_hit, hit, is_wr, ram_we;
    logic [31:0]           wmask, merged, rd_word;
    logic                  unused_bits;

    assign idx     = data_sram_addr[TAG_LSB-1:2];
    assign ram_hit = (data_sram_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    assign is_wr   = |data_sram_wen;

    // Write-first: enabled bytes of wdata override the stored word.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < 4; i++) begin
            wmask[8*i +: 8] = {8{data_sram_wen[i]}};
        end
    end
    assign merged = (data_sram_wdata & wmask) | (mem_q[idx] & ~wmask);

`ifdef DATA_SRAM_TIMER_EN
    logic [31:0] timer_q, timer_d;
    logic        timer_hit;

    assign timer_hit   = (data_sram_addr[31:2] == TIMER_ADDR[31:2]);
    assign hit         = ram_hit | timer_hit;
    assign ram_we      = data_sram_en & ram_hit & ~timer_hit & is_wr;
    assign rd_word     = timer_hit ? timer_q : merged;
    assign unused_bits = ^data_sram_addr[1:0];

    // A full-word load lands as wdata+1 so the next-cycle read already sees one tick.
    always_comb begin
        timer_d = timer_q + 32'd1;
        if (data_sram_en && timer_hit && (data_sram_wen == 4'b1111)) begin
            timer_d = data_sram_wdata + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) timer_q <= '0;
        else     timer_q <= timer_d;
    end
`else
    assign hit         = ram_hit;
    assign ram_we      = data_sram_en & ram_hit & is_wr;
    assign rd_word     = merged;
    assign unused_bits = ^{data_sram_addr[1:0], TIMER_ADDR};
`endif

    always_comb begin
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (data_sram_en) begin
            if (hit) begin
                rdata_d = rd_word;
                if (is_wr) wr_cnt_d = wr_cnt_q + 32'd1;
                else       rd_cnt_d = rd_cnt_q + 32'd1;
            end else begin
                rdata_d = '0;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= '0;
            err_q    <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Array is not reset; requests seen while rst is high are dropped.
    always_ff @(posedge clk) begin
        if (!rst && ram_we) mem_q[idx] <= merged;
    end

    assign data_sram_rdata = rdata_q;
    assign resp_err        = err_q;
    assign stat_rd_cnt     = rd_cnt_q;
    assign stat_wr_cnt     = wr_cnt_q;
endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: scoreboard bench for data_sram_resp against a word-array reference model.
module tb_data_sram_resp;
    localparam logic [31:0] TIMER_A = 32'h1FAF_E000;
    localparam logic [31:0] RAM_END = 32'h0000_4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        resp_err;
    logic [31:0] stat_rd_cnt;
    logic [31:0] stat_wr_cnt;

    data_sram_resp dut (
        .clk(clk), .rst(rst),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata), .resp_err(resp_err),
        .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] rd;
        logic [31:0] wr;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] mem_m [int];
    logic [31:0] rd_m, wr_m, last_m;
    logic [31:0] tval;
    int unsigned tcyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every response whose registering edge has passed.
    always @(negedge clk) begin
        if (!rst) begin
            while (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("resp_cycle", cyc, e.due);
                chk("rdata", data_sram_rdata, e.rdata);
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                chk("stat_rd_cnt", stat_rd_cnt, e.rd);
                chk("stat_wr_cnt", stat_wr_cnt, e.wr);
            end
        end
    end

    // Drive one request for one cycle and queue the response the model predicts.
    task automatic req(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata);
        exp_t        e;
        logic [31:0] mg;
        int          w;
        logic        tim;
        data_sram_en    = en;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        w   = int'(addr >> 2);
`ifdef DATA_SRAM_TIMER_EN
        tim = ((addr >> 2) == (TIMER_A >> 2));
`else
        tim = 1'b0;
`endif
        e.due   = cyc + 1;
        e.err   = 1'b0;
        e.rdata = last_m;
        if (en) begin
            if (tim) begin
                e.rdata = tval + 32'(cyc + 1 - tcyc);
                if (wen != 4'd0) wr_m++; else rd_m++;
                if (wen == 4'hF) begin
                    tval = wdata;
                    tcyc = cyc + 1;
                end
            end else if (addr < RAM_END) begin
                mg = mem_m.exists(w) ? mem_m[w] : 32'd0;
                for (int b = 0; b < 4; b++) begin
                    if (wen[b]) mg[8*b +: 8] = wdata[8*b +: 8];
                end
                if (wen != 4'd0) begin
                    mem_m[w] = mg;
                    wr_m++;
                end else begin
                    rd_m++;
                end
                e.rdata = mg;
            end else begin
                e.rdata = 32'd0;
                e.err   = 1'b1;
            end
        end
        last_m = e.rdata;
        e.rd = rd_m;
        e.wr = wr_m;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        rd_m   = 32'd0;
        wr_m   = 32'd0;
        last_m = 32'd0;
        tval   = 32'd0;
        tcyc   = cyc + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        data_sram_en = 1'b0;
        data_sram_wen = 4'd0;
        data_sram_addr = 32'd0;
        data_sram_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdata", data_sram_rdata, 32'd0);
        chk("reset_err", {31'd0, resp_err}, 32'd0);
        chk("reset_rd_cnt", stat_rd_cnt, 32'd0);
        chk("reset_wr_cnt", stat_wr_cnt, 32'd0);
        rst = 1'b0;
        model_reset();

        // Full write then read back
        req(1'b1, 4'hF, 32'h0000_0010, 32'hA5A5_1234);
        req(1'b1, 4'h0, 32'h0000_0010, 32'd0);
        // Partial write with write-first merge
        req(1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344);
        req(1'b1, 4'h5, 32'h0000_0020, 32'hAABB_CCDD);
        req(1'b1, 4'h0, 32'h0000_0020, 32'd0);
        // Unmapped accesses, aliasing index of 0x10, must not disturb RAM
        req(1'b1, 4'h0, 32'h8000_0000, 32'd0);
        req(1'b1, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF);
        req(1'b1, 4'h0, 32'h0000_0010, 32'd0);
        req(1'b1, 4'h0, 32'h0000_3FFC, 32'd0);
        req(1'b1, 4'hF, 32'h0000_4000, 32'h0BAD_0BAD);
        req(1'b1, 4'h0, TIMER_A, 32'd0);
        // Idle hold
        req(1'b1, 4'h0, 32'h0000_0010, 32'd0);
        repeat (3) req(1'b0, 4'hF, 32'h0000_0010, 32'hFFFF_FFFF);

        // Asynchronous reset mid-stream with a write held through it
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'hF;
        data_sram_addr  = 32'h0000_0010;
        data_sram_wdata = 32'hDEAD_0000;
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        chk("async_rst_rdata", data_sram_rdata, 32'd0);
        chk("async_rst_err", {31'd0, resp_err}, 32'd0);
        chk("async_rst_rd_cnt", stat_rd_cnt, 32'd0);
        chk("async_rst_wr_cnt", stat_wr_cnt, 32'd0);
        @(posedge clk);
        #1;
        data_sram_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        req(1'b1, 4'h0, 32'h0000_0010, 32'd0);

        // Write counter wrap
        data_sram_en = 1'b0;
        @(negedge clk);
        #1;
        force dut.wr_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.wr_cnt_q;
        wr_m = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        req(1'b1, 4'hF, 32'h0000_0030, 32'h0000_0001);
        req(1'b1, 4'h3, 32'h0000_0030, 32'h1234_5678);

`ifdef DATA_SRAM_TIMER_EN
        req(1'b1, 4'hF, TIMER_A, 32'hFFFF_FFFE);
        req(1'b1, 4'h0, TIMER_A, 32'd0);
        req(1'b1, 4'h0, TIMER_A, 32'd0);
        req(1'b1, 4'h3, TIMER_A, 32'h0000_1234);
        req(1'b1, 4'h0, TIMER_A, 32'd0);
`endif

        // Randomized traffic over a small preloaded word set plus unmapped space
        for (int k = 0; k < 8; k++) req(1'b1, 4'hF, 32'h0000_0100 + 32'(4 * k), $urandom);
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) a = 32'h8000_0000 | $urandom;
            else a = 32'h0000_0100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            req($urandom_range(0, 4) != 0,
                ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                a, $urandom);
        end

        data_sram_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drain", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
